add24_arbiter: RTL and testbench

ADD24_ARBITER -- requirements
Module: add24_arbiter

---
 rtl/add24_arbiter.sv | 115 +++++++++++
 tb/tb_add24_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/add24_arbiter.sv
// add24_arbiter: two requesters share one 24-bit CLA through a 2-stage pipeline
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_reqN_valid/o_reqN_ready          requester N handshake (N = 0, 1)
//   i_reqN_a, i_reqN_b, i_reqN_cin     requester N operands
//   o_rsp_valid/i_rsp_ready            result handshake
//   o_rsp_sum, o_rsp_carry, o_rsp_id   {carry, sum} = a + b + cin, owning requester
//   o_inflight                         accepted but unreturned operations (0..2)
// Config: define ADD24_ARB_RR_EN for round-robin arbitration, otherwise
//   requester 0 has fixed priority.

module CLA_24bit (
   input  logic [23:0] a,
   input  logic [23:0] b,
   input  logic        cin,
   output logic [23:0] sum,
   output logic        cout
);
   logic [23:0] g, p;
   logic [24:0] c;
   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = cin;
   // Six 4-bit lookahead groups; carries ripple between groups.
   for (genvar k = 0; k < 6; k++) begin : grp
      logic [3:0] gg, pp;
      logic       ci;
      assign gg = g[4*k +: 4];
      assign pp = p[4*k +: 4];
      assign ci = c[4*k];
      assign c[4*k+1] = gg[0] | (pp[0] & ci);
      assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & ci);
      assign c[4*k+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                      | (pp[3] & pp[2] & pp[1] & gg[0])
                      | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
   end
   assign sum  = p ^ c[23:0];
   assign cout = c[24];
endmodule

module add24_arbiter (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [23:0] i_req0_a,
   input  logic [23:0] i_req0_b,
   input  logic        i_req0_cin,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [23:0] i_req1_a,
   input  logic [23:0] i_req1_b,
   input  logic        i_req1_cin,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [23:0] o_rsp_sum,
   output logic        o_rsp_carry,
   output logic        o_rsp_id,
   output logic [1:0]  o_inflight
);
   logic        s1_valid, s1_cin, s1_id;
   logic [23:0] s1_a, s1_b, add_sum;
   logic        add_cout, s1_free, s2_free, gnt1, acc, rsp_fire;
   assign s2_free  = ~o_rsp_valid | i_rsp_ready;
   assign s1_free  = ~s1_valid | s2_free;
   assign rsp_fire = o_rsp_valid & i_rsp_ready;
`ifdef ADD24_ARB_RR_EN
   logic last;
   // On a contest the requester not served last wins; reset makes 0 win first.
   assign gnt1 = i_req1_valid & (~i_req0_valid | ~last);
   always_ff @(posedge i_clk)
      if (i_rst) last <= 1'b1;
      else if (acc) last <= gnt1;
`else
   assign gnt1 = i_req1_valid & ~i_req0_valid;
`endif
   assign o_req0_ready = ~i_rst & s1_free & i_req0_valid & ~gnt1;
   assign o_req1_ready = ~i_rst & s1_free & gnt1;
   assign acc          = o_req0_ready | o_req1_ready;
   CLA_24bit u_cla (.a(s1_a), .b(s1_b), .cin(s1_cin), .sum(add_sum), .cout(add_cout));
   always_ff @(posedge i_clk)
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_cin   <= 1'b0;
         s1_id    <= 1'b0;
      end else if (acc) begin
         s1_valid <= 1'b1;
         s1_a     <= gnt1 ? i_req1_a : i_req0_a;
         s1_b     <= gnt1 ? i_req1_b : i_req0_b;
         s1_cin   <= gnt1 ? i_req1_cin : i_req0_cin;
         s1_id    <= gnt1;
      end else if (s2_free) s1_valid <= 1'b0;
   always_ff @(posedge i_clk)
      if (i_rst) begin
         o_rsp_valid <= 1'b0;
         o_rsp_sum   <= '0;
         o_rsp_carry <= 1'b0;
         o_rsp_id    <= 1'b0;
      end else if (s2_free) begin
         o_rsp_valid <= s1_valid;
         if (s1_valid) begin
            o_rsp_sum   <= add_sum;
            o_rsp_carry <= add_cout;
            o_rsp_id    <= s1_id;
         end
      end
   always_ff @(posedge i_clk)
      if (i_rst) o_inflight <= 2'd0;
      else if (acc & ~rsp_fire) o_inflight <= o_inflight + 2'd1;
      else if (~acc & rsp_fire) o_inflight <= o_inflight - 2'd1;
endmodule

// File: tb/tb_add24_arbiter.sv
// tb_add24_arbiter: randomized and directed checks of add24_arbiter against a queue model
module tb_add24_arbiter;
`ifdef ADD24_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   typedef struct packed {logic [23:0] sum; logic carry; logic id;} rsp_t;
   logic        clk = 1'b0;
   logic        rst, v0, v1, c0, c1, rsp_ready;
   logic [23:0] a0, b0, a1, b1;
   logic        r0, r1, rsp_valid, rsp_carry, rsp_id;
   logic [23:0] rsp_sum;
   logic [1:0]  inflight;
   logic        n_rst = 1'b0, n_v0 = 1'b0, n_v1 = 1'b0, n_c0 = 1'b0, n_c1 = 1'b0, n_rr = 1'b1;
   logic [23:0] n_a0 = '0, n_b0 = '0, n_a1 = '0, n_b1 = '0;
   rsp_t        q[$];
   int          last_served = 1;
   int          n_checks = 0, n_errors = 0;
   logic        prev_stall = 1'b0;
   rsp_t        prev_rsp;
   logic        acc_flag, fire_flag;
   int          acc_id;

   always #5 clk = ~clk;

   add24_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_cin(c0),
      .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_cin(c1),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_sum(rsp_sum),
      .o_rsp_carry(rsp_carry), .o_rsp_id(rsp_id), .o_inflight(inflight)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic rsp_t ref_add(input logic [23:0] a, input logic [23:0] b,
                                    input logic cin, input logic id);
      logic [24:0] s;
      s = 25'(a) + 25'(b) + 25'(cin);
      return '{sum: s[23:0], carry: s[24], id: id};
   endfunction

   function automatic logic [23:0] rnd_op();
      int k;
      k = $urandom_range(0, 7);
      return k == 0 ? 24'hFFFFFF : k == 1 ? 24'h000000 : 24'($urandom);
   endfunction

   // One clock: apply the queued inputs at the falling edge, then check the
   // settled outputs against the model and advance the model.
   task automatic step();
      int   win;
      logic any;
      @(negedge clk);
      rst = n_rst; v0 = n_v0; v1 = n_v1; a0 = n_a0; b0 = n_b0; c0 = n_c0;
      a1 = n_a1; b1 = n_b1; c1 = n_c1; rsp_ready = n_rr;
      #1;
      if (prev_stall) begin
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_data", 32'({rsp_sum, rsp_carry, rsp_id}), 32'(prev_rsp));
      end
      win = (v0 && v1) ? (RR ? (last_served == 1 ? 0 : 1) : 0) : (v1 ? 1 : 0);
      any = !rst && (v0 || v1) && (q.size() < 2 || rsp_ready);
      check("ready0", 32'(r0), 32'(any && win == 0));
      check("ready1", 32'(r1), 32'(any && win == 1));
      check("inflight", 32'(inflight), 32'(q.size()));
      fire_flag = rsp_valid && rsp_ready && !rst;
      if (fire_flag) begin
         if (q.size() == 0) check("stale_rsp", 32'(rsp_valid), 32'd0);
         else check("rsp", 32'({rsp_sum, rsp_carry, rsp_id}), 32'(q.pop_front()));
      end
      acc_flag = any;
      acc_id   = win;
      if (rst) begin
         q.delete();
         last_served = 1;
      end else if (any) begin
         q.push_back(win == 1 ? ref_add(a1, b1, c1, 1'b1) : ref_add(a0, b0, c0, 1'b0));
         last_served = win;
      end
      prev_stall = !rst && rsp_valid && !rsp_ready;
      prev_rsp   = '{sum: rsp_sum, carry: rsp_carry, id: rsp_id};
   endtask

   initial begin
      int cnt0, cnt1, acc_cnt, rsp_cnt;
      logic [7:0] ord;
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0;
      a1 = '0; b1 = '0; c1 = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      n_rst = 1'b0;
      step();
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_data", 32'({rsp_sum, rsp_carry, rsp_id}), 32'd0);
      // Single op latency
      n_v0 = 1'b1; n_a0 = 24'h123456; n_b0 = 24'h654321; n_c0 = 1'b1;
      step();
      check("acc_single", 32'(r0), 32'd1);
      n_v0 = 1'b0;
      step();
      check("lat1_valid", 32'(rsp_valid), 32'd0);
      check("lat1_inflight", 32'(inflight), 32'd1);
      step();
      check("lat2_valid", 32'(rsp_valid), 32'd1);
      check("single_sum", 32'(rsp_sum), 32'h777778);
      check("single_carry", 32'(rsp_carry), 32'd0);
      check("single_id", 32'(rsp_id), 32'd0);
      step();
      check("single_done", 32'(inflight), 32'd0);
      // Overflow on requester 1
      n_v1 = 1'b1; n_a1 = 24'hFFFFFF; n_b1 = 24'h000001; n_c1 = 1'b0;
      step();
      n_v1 = 1'b0;
      step();
      step();
      check("ovf_valid", 32'(rsp_valid), 32'd1);
      check("ovf_sum", 32'(rsp_sum), 32'd0);
      check("ovf_carry", 32'(rsp_carry), 32'd1);
      check("ovf_id", 32'(rsp_id), 32'd1);
      step();
      // Contention: four ops from each requester
      cnt0 = 0; cnt1 = 0; ord = '0;
      for (int i = 0; i < 40 && (cnt0 < 4 || cnt1 < 4); i++) begin
         n_v0 = cnt0 < 4; n_v1 = cnt1 < 4;
         n_a0 = rnd_op(); n_b0 = rnd_op(); n_c0 = 1'($urandom);
         n_a1 = rnd_op(); n_b1 = rnd_op(); n_c1 = 1'($urandom);
         step();
         if (r0 || r1) ord = {ord[6:0], r1};
         cnt0 += int'(r0); cnt1 += int'(r1);
      end
      check("grant_order", 32'(ord), RR ? 32'h55 : 32'h0F);
      n_v0 = 1'b0; n_v1 = 1'b0;
      repeat (4) step();
      // Backpressure
      n_rr = 1'b0; n_v0 = 1'b1; acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         n_a0 = rnd_op(); n_b0 = rnd_op(); n_c0 = 1'($urandom);
         step();
         acc_cnt += int'(r0);
      end
      check("bp_accepts", 32'(acc_cnt), 32'd2);
      check("bp_inflight", 32'(inflight), 32'd2);
      check("bp_ready", 32'({r0, r1}), 32'd0);
      n_rr = 1'b1; n_v0 = 1'b0; rsp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         rsp_cnt += int'(fire_flag);
      end
      check("bp_responses", 32'(rsp_cnt), 32'd2);
      // Reset with two operations in flight
      n_rr = 1'b0; n_v0 = 1'b1;
      repeat (3) step();
      check("pre_rst_inflight", 32'(inflight), 32'd2);
      n_rst = 1'b1; n_v0 = 1'b0;
      step();
      n_rst = 1'b0; n_rr = 1'b1;
      step();
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_inflight", 32'(inflight), 32'd0);
      repeat (4) step();
      // Random traffic
      acc_cnt = 0;
      for (int i = 0; i < 60000 && acc_cnt < 10000; i++) begin
         n_rst = $urandom_range(0, 1999) == 0;
         n_v0 = $urandom_range(0, 9) < 6; n_v1 = $urandom_range(0, 9) < 6;
         n_rr = $urandom_range(0, 9) < 7;
         n_a0 = rnd_op(); n_b0 = rnd_op(); n_c0 = 1'($urandom);
         n_a1 = rnd_op(); n_b1 = rnd_op(); n_c1 = 1'($urandom);
         step();
         acc_cnt += int'(acc_flag);
      end
      n_rst = 1'b0; n_v0 = 1'b0; n_v1 = 1'b0; n_rr = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      step();
      check("drain_empty", 32'(q.size()), 32'd0);
      check("drain_valid", 32'(rsp_valid), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
